xbar_matrix: RTL

XBAR_MATRIX -- requirements
Module: xbar_matrix

---
 rtl/xbar_pkg.sv | 18 +
 rtl/demux.sv | 20 ++
 rtl/xbar_matrix.sv | 139 +++++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared opcode and FSM encodings for the crossbar routing matrix.
package xbar_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_CONNECT    = 2'd0,
        OP_DISCONNECT = 2'd1,
        OP_QUERY      = 2'd2,
        OP_CLEAR      = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/demux.sv
// One-hot decoder: out_o[k] is set when enabled and sel_i == k; out-of-range selects decode to zero.
module demux #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = 4
) (
    input  logic          en_i,
    input  logic [SW-1:0] sel_i,
    output logic [N-1:0]  out_o
);

    always_comb begin
        out_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (en_i && (sel_i == SW'(k))) begin
                out_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_matrix.sv
// Configurable W-bit crossbar: OUT columns of IN-bit source masks, OR-combined lanes,
// command port for connect/disconnect/query and a one-column-per-cycle CLEAR sweep.
module xbar_matrix
    import xbar_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned IN   = 8,
    parameter int unsigned OUT  = 8,
    parameter int unsigned AW   = 4,
    parameter int unsigned EXCL = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IN*W-1:0]   in,
    output logic [OUT*W-1:0]  out,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [AW-1:0]     cmd_from,
    input  logic [AW-1:0]     cmd_to,
    output logic [IN-1:0]     rd_data,
    output logic              rd_valid
);

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [OUT-1:0][IN-1:0]  mask_q, mask_d;
    logic [OUT*W-1:0]        out_q, out_d;
    logic [IN-1:0]           rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    ready_q;
    logic [OUT-1:0]          to_oh;
    logic [IN-1:0]           from_oh;
    logic                    accept_c;
    logic                    addr_ok_c;
    op_e                     op_c;

    demux #(.N(OUT), .SW(AW)) u_col_dec (.en_i(1'b1), .sel_i(cmd_to),   .out_o(to_oh));
    demux #(.N(IN),  .SW(AW)) u_row_dec (.en_i(1'b1), .sel_i(cmd_from), .out_o(from_oh));

    assign op_c      = op_e'(cmd_op);
    assign accept_c  = cmd_valid && ready_q;
    // Out-of-range indices decode to all-zero, which disqualifies the write.
    assign addr_ok_c = (|to_oh) && (|from_oh);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    case (op_c)
                        OP_CONNECT: begin
                            for (int unsigned j = 0; j < OUT; j++) begin
                                if (addr_ok_c && to_oh[j]) begin
                                    mask_d[j] = (EXCL != 0) ? from_oh : (mask_q[j] | from_oh);
                                end
                            end
                        end
                        OP_DISCONNECT: begin
                            for (int unsigned j = 0; j < OUT; j++) begin
                                if (addr_ok_c && to_oh[j]) begin
                                    mask_d[j] = mask_q[j] & ~from_oh;
                                end
                            end
                        end
                        OP_QUERY: begin
                            rd_valid_d = 1'b1;
                            for (int unsigned j = 0; j < OUT; j++) begin
                                if (to_oh[j]) begin
                                    rd_data_d = rd_data_d | mask_q[j];
                                end
                            end
                        end
                        OP_CLEAR: begin
                            state_d = ST_SWEEP;
                            cnt_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SWEEP: begin
                for (int unsigned j = 0; j < OUT; j++) begin
                    if (cnt_q == AW'(j)) begin
                        mask_d[j] = '0;
                    end
                end
                if (cnt_q == AW'(OUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane combine uses the current matrix, so a matrix change shows one edge later.
    always_comb begin
        out_d = '0;
        for (int unsigned j = 0; j < OUT; j++) begin
            for (int unsigned i = 0; i < IN; i++) begin
                if (mask_q[j][i]) begin
                    out_d[j*W +: W] = out_d[j*W +: W] | in[i*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            out_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            out_q      <= out_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= (state_d == ST_IDLE);
        end
    end

    assign out       = out_q;
    assign cmd_ready = ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule
